// File: rtl/store_byte_serializer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : store_byte_serializer_if
// Brief  : Request and byte-wide memory-write bundle for the store byte
//          serializer. The master modport is the core/bench side and the
//          slave modport is the serializer side.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface store_byte_serializer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Store request from the core
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [1:0]            req_size;

  // Byte-wide memory write port
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  // Completion status pulses
  logic                  done;
  logic                  misaligned;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, done, misaligned
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, done, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/store_byte_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : store_byte_serializer
// Brief  : Accepts one SB/SH/SW store request and emits it as a
//          little-endian byte stream, one byte per memory handshake.
//          Misaligned or illegal-size requests are rejected with a
//          one-cycle pulse and generate no memory traffic.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module store_byte_serializer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  store_byte_serializer_if.slave  bus
);

  // Encoded states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // Request size encodings
  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;
  localparam logic [1:0] C_SIZE_WORD = 2'b10;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic [1:0]            last_q,    last_d;
  logic [1:0]            idx_q,     idx_d;

  logic                  w_accept;
  logic                  w_legal;
  logic [1:0]            w_last_idx;
  logic                  w_beat;
  logic [DATA_WIDTH-1:0] w_shifted;

  // A request is only taken in IDLE and never while reset is asserted, so
  // req_ready reads low during the reset cycle itself.
  assign bus.req_ready = rst_n && (state_q == S_IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;

  // Legality and final byte index of the incoming request
  always_comb begin
    w_legal    = 1'b0;
    w_last_idx = 2'd0;
    case (bus.req_size)
      C_SIZE_BYTE: begin
        w_legal    = 1'b1;
        w_last_idx = 2'd0;
      end
      C_SIZE_HALF: begin
        w_legal    = (bus.req_addr[0] == 1'b0);
        w_last_idx = 2'd1;
      end
      C_SIZE_WORD: begin
        w_legal    = (bus.req_addr[1:0] == 2'b00);
        w_last_idx = 2'd3;
      end
      default: begin
        w_legal    = 1'b0;
        w_last_idx = 2'd0;
      end
    endcase
  end

  // One byte leaves per accepted memory handshake
  assign w_beat = (state_q == S_SEND) && bus.mem_ready;

  // Next-state and datapath capture logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          addr_d = bus.req_addr;
          data_d = bus.req_data;
          last_d = w_last_idx;
          idx_d  = 2'd0;
          if (w_legal) begin
            state_d = S_SEND;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SEND: begin
        if (w_beat) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any store in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 2'd0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  // Select the current byte: little-endian, byte idx from the low end
  assign w_shifted = data_q >> {idx_q, 3'b000};

  // Byte port is driven only in SEND and reads as zero otherwise; address
  // wraps modulo 2^ADDR_WIDTH naturally through the adder width.
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'h00;
    if (state_q == S_SEND) begin
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q};
      bus.mem_wdata = w_shifted[7:0];
    end
  end

  // Status pulses are one state each, so they can never overlap
  assign bus.done       = (state_q == S_DONE);
  assign bus.misaligned = (state_q == S_ERR);

endmodule
`default_nettype wire
